// File: rtl/cmp_share_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cmp_sched_pkg
// Purpose  : Shared types for the shared-comparator scheduler: FSM states,
//            the three-way comparison result and its all-zero constant.
// Revision : 1.0 - initial release
// ============================================================================
package cmp_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    RESP = 2'd2
  } cmp_state_t;

  typedef struct packed {
    logic gt;
    logic eq;
    logic lt;
  } cmp_res_t;

  localparam cmp_res_t CMP_RES_NONE = '{gt: 1'b0, eq: 1'b0, lt: 1'b0};

endpackage
`default_nettype wire

// File: rtl/cmp_share_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : cmp_share_sched_if
// Purpose  : Requester channels plus the shared response channel of the
//            comparator scheduler. master = requesters/consumer side,
//            slave = scheduler side.
// Revision : 1.0 - initial release
// ============================================================================
interface cmp_share_sched_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 16,
  parameter int ID_W  = $clog2(N_REQ)
);

  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ*WIDTH-1:0] req_a;
  logic [N_REQ*WIDTH-1:0] req_b;
  logic                   resp_valid;
  logic                   resp_ready;
  logic [ID_W-1:0]        resp_id;
  logic                   resp_gt;
  logic                   resp_eq;
  logic                   resp_lt;

  modport master (
    output req_valid, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_gt, resp_eq, resp_lt
  );

  modport slave (
    input  req_valid, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_id, resp_gt, resp_eq, resp_lt
  );

endinterface
`default_nettype wire

// File: rtl/cmp_share_sched_cmp3.sv
`default_nettype none
// ============================================================================
// Module   : cmp3_core
// Purpose  : Combinational unsigned three-way magnitude comparator. This is
//            the single resource shared among all requesters.
// Revision : 1.0 - initial release
// ============================================================================
module cmp3_core
  import cmp_sched_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output cmp_res_t         res
);

  // Plain unsigned relational operators; exactly one flag is ever set.
  always_comb begin
    res    = CMP_RES_NONE;
    res.gt = (a > b);
    res.eq = (a == b);
    res.lt = (a < b);
  end

endmodule
`default_nettype wire

// File: rtl/cmp_share_sched.sv
`default_nettype none
// ============================================================================
// Module   : cmp_share_sched
// Purpose  : Round-robin scheduler sharing one three-way comparator among
//            N_REQ requesters. One comparison in flight: IDLE (grant and
//            capture operands) -> CMP (register result) -> RESP (hold until
//            the consumer accepts).
// Revision : 1.0 - initial release
// ============================================================================
module cmp_share_sched
  import cmp_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 16,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  cmp_share_sched_if.slave bus,
  output logic             busy
);

  cmp_state_t       state_q;
  cmp_state_t       state_d;
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  grant_id;
  logic             grant_vld;
  logic             take;
  logic [N_REQ-1:0] ready_d;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [ID_W-1:0]  op_id;
  logic [ID_W-1:0]  res_id;
  cmp_res_t         cmp_out;
  cmp_res_t         res_q;

  // Requester index 'off' positions above 'base', wrapping at N_REQ
  // (N_REQ need not be a power of two).
  function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base,
                                               input int off);
    int s;
    s = 32'(base) + off;
    if (s >= N_REQ) s = s - N_REQ;
    return ID_W'(s);
  endfunction

  // Round-robin search: first valid requester at or above rr_ptr.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!grant_vld && bus.req_valid[wrap_add(rr_ptr, i)]) begin
        grant_vld = 1'b1;
        grant_id  = wrap_add(rr_ptr, i);
      end
    end
  end

  // Next-state and grant decode; ready is suppressed while reset is held.
  always_comb begin
    state_d = state_q;
    ready_d = '0;
    take    = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_vld && !rst) begin
          ready_d[grant_id] = 1'b1;
          take              = 1'b1;
          state_d           = CMP;
        end
      end
      CMP:     state_d = RESP;
      RESP:    if (bus.resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Operand capture and pointer advance on the request handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
      op_a   <= '0;
      op_b   <= '0;
      op_id  <= '0;
    end else if (take) begin
      op_a   <= bus.req_a[grant_id*WIDTH +: WIDTH];
      op_b   <= bus.req_b[grant_id*WIDTH +: WIDTH];
      op_id  <= grant_id;
      rr_ptr <= wrap_add(grant_id, 1);
    end
  end

  cmp3_core #(.WIDTH(WIDTH)) u_cmp (
    .a   (op_a),
    .b   (op_b),
    .res (cmp_out)
  );

  // Result registers load in CMP and stay frozen through RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_q  <= CMP_RES_NONE;
      res_id <= '0;
    end else if (state_q == CMP) begin
      res_q  <= cmp_out;
      res_id <= op_id;
    end
  end

  assign bus.req_ready  = ready_d;
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_id    = res_id;
  assign bus.resp_gt    = res_q.gt;
  assign bus.resp_eq    = res_q.eq;
  assign bus.resp_lt    = res_q.lt;
  assign busy           = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_cmp_share_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_cmp_share_sched
// Purpose  : Scoreboard bench for cmp_share_sched. Grants push hand-computed
//            expected results; an independent monitor pops on each response.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cmp_share_sched;

  localparam int N   = 4;
  localparam int W   = 16;
  localparam int IDW = 2;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2:0]     exp;   // {gt, eq, lt}
  } vec_t;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [2:0]     f;
  } exp_t;

  localparam logic [2:0] GT = 3'b100;
  localparam logic [2:0] EQ = 3'b010;
  localparam logic [2:0] LT = 3'b001;

  logic clk = 1'b0;
  logic rst;
  logic busy;

  always #5 clk = ~clk;

  cmp_share_sched_if #(.N_REQ(N), .WIDTH(W)) bus ();

  cmp_share_sched #(.N_REQ(N), .WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus.slave),
    .busy (busy)
  );

  int         checks = 0;
  int         errors = 0;
  vec_t       vq[$];
  vec_t       pend[N];
  logic [N-1:0] pv = '0;
  exp_t       sb[$];
  int         glog[$];
  int         wait_cnt[N];
  logic [N-1:0] last_ready;
  logic       last_rv;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic add(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [2:0] e);
    vec_t v;
    v.id = IDW'(id); v.a = a; v.b = b; v.exp = e;
    vq.push_back(v);
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      bus.req_a[i*W +: W] = pend[i].a;
      bus.req_b[i*W +: W] = pend[i].b;
    end
    bus.req_valid = pv;
  endtask

  // Give every idle requester its next queued vector, in queue order.
  task automatic load();
    for (int i = 0; i < N; i++) begin
      if (!pv[i]) begin
        for (int k = 0; k < vq.size(); k++) begin
          if (32'(vq[k].id) == i) begin
            pend[i] = vq[k];
            pv[i]   = 1'b1;
            vq.delete(k);
            break;
          end
        end
      end
    end
    drive();
  endtask

  // One clock: sample grants at negedge, push expectations, release
  // granted requesters just after the rising edge.
  task automatic step();
    logic [N-1:0] hs;
    exp_t e;
    @(negedge clk);
    last_ready = bus.req_ready;
    last_rv    = bus.resp_valid;
    checks++;
    if (((bus.req_ready & ~pv) != '0) || !$onehot0(bus.req_ready)) begin
      errors++;
      $display("FAIL grant_legal actual=%b required=onehot0_subset_of_%b", bus.req_ready, pv);
    end
    hs = bus.req_ready & pv;
    for (int i = 0; i < N; i++) begin
      if (hs[i]) begin
        e.id = IDW'(i);
        e.f  = pend[i].exp;
        sb.push_back(e);
        glog.push_back(i);
        chk($sformatf("fair_wait_r%0d", i), 32'(wait_cnt[i]) <= 32'(N-1) ? 32'd1 : 32'd0, 32'd1);
        wait_cnt[i] = 0;
        for (int j = 0; j < N; j++)
          if (j != i && pv[j]) wait_cnt[j]++;
      end
    end
    @(posedge clk);
    #1;
    pv = pv & ~hs;
    load();
  endtask

  task automatic drain(input bit rnd_ready);
    int n;
    n = 0;
    do begin
      bus.resp_ready = rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
      step();
      n++;
    end while (!(pv == '0 && vq.size() == 0 && sb.size() == 0 && !busy) && n < 300);
    chk("drain_timeout", (n >= 300) ? 32'd1 : 32'd0, 32'd0);
    bus.resp_ready = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    pv  = '0;
    drive();
    sb.delete();
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Response monitor: pops the scoreboard on every response handshake and
  // checks hold stability while the consumer stalls.
  logic       hold_v = 1'b0;
  logic [4:0] hold;
  always @(negedge clk) begin
    exp_t e;
    if (bus.resp_valid) begin
      if (hold_v) begin
        checks++;
        if ({bus.resp_id, bus.resp_gt, bus.resp_eq, bus.resp_lt} !== hold) begin
          errors++;
          $display("FAIL resp_stable actual=%h required=%h",
                   {bus.resp_id, bus.resp_gt, bus.resp_eq, bus.resp_lt}, hold);
        end
      end
      checks++;
      if (!$onehot({bus.resp_gt, bus.resp_eq, bus.resp_lt})) begin
        errors++;
        $display("FAIL resp_onehot actual=%b required=onehot",
                 {bus.resp_gt, bus.resp_eq, bus.resp_lt});
      end
      if (bus.resp_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL resp_unexpected actual=id%0d required=no_response", bus.resp_id);
        end else begin
          e = sb.pop_front();
          if (bus.resp_id !== e.id || {bus.resp_gt, bus.resp_eq, bus.resp_lt} !== e.f) begin
            errors++;
            $display("FAIL resp_data actual=id%0d f%b required=id%0d f%b",
                     bus.resp_id, {bus.resp_gt, bus.resp_eq, bus.resp_lt}, e.id, e.f);
          end
        end
        hold_v = 1'b0;
      end else begin
        hold_v = 1'b1;
        hold   = {bus.resp_id, bus.resp_gt, bus.resp_eq, bus.resp_lt};
      end
    end else begin
      hold_v = 1'b0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      pend[i]     = '0;
      wait_cnt[i] = 0;
    end
    rst            = 1'b1;
    bus.resp_ready = 1'b1;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.req_valid  = '0;

    // Reset state, with a valid request already presented.
    add(0, 16'h1234, 16'h1234, EQ);
    load();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_resp_id", 32'(bus.resp_id), 32'd0);
    chk("rst_flags", 32'({bus.resp_gt, bus.resp_eq, bus.resp_lt}), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Single equal compare: handshake in cycle 1, response two cycles later.
    step();
    chk("t1_ready", 32'(last_ready), 32'b0001);
    step();
    chk("t1_cmp_no_resp", 32'(last_rv), 32'd0);
    step();
    chk("t1_resp_latency", 32'(last_rv), 32'd1);
    drain(1'b0);

    // All four valid, pointer from reset: order 0,1,2,3,0.
    do_reset();
    glog.delete();
    add(0, 16'h0005, 16'h0003, GT);
    add(1, 16'h00AA, 16'h00AA, EQ);
    add(2, 16'hFFFF, 16'h0000, GT);
    add(3, 16'h0001, 16'h8000, LT);
    add(0, 16'h7FFF, 16'h8000, LT);
    load();
    drain(1'b0);
    chk("t2_grant_count", 32'(glog.size()), 32'd5);
    for (int k = 0; k < 5; k++)
      chk($sformatf("t2_grant%0d", k), (k < glog.size()) ? 32'(glog[k]) : 32'hFFFF,
          (k == 4) ? 32'd0 : 32'(k));

    // Consumer stall: ten RESP cycles with resp_ready low.
    bus.resp_ready = 1'b0;
    add(1, 16'h0003, 16'h0009, LT);
    load();
    step();
    chk("t3_ready_r1", 32'(last_ready), 32'b0010);
    add(2, 16'h0010, 16'h0010, EQ);
    load();
    step();
    chk("t3_cmp_ready", 32'(last_ready), 32'd0);
    for (int c = 0; c < 10; c++) begin
      step();
      chk("t3_stall_ready", 32'(last_ready), 32'd0);
      chk("t3_stall_valid", 32'(last_rv), 32'd1);
    end
    bus.resp_ready = 1'b1;
    step();
    chk("t3_resp_hs_ready", 32'(last_ready), 32'd0);
    step();
    chk("t3_next_accept", 32'(last_ready), 32'b0100);
    drain(1'b0);

    // Wrap-around: pointer at 3, only requester 1 valid.
    do_reset();
    add(2, 16'h0002, 16'h0001, GT);
    load();
    drain(1'b0);
    glog.delete();
    add(1, 16'h4000, 16'h4000, EQ);
    load();
    drain(1'b0);
    chk("t4_wrap_count", 32'(glog.size()), 32'd1);
    chk("t4_wrap_grant", (glog.size() > 0) ? 32'(glog[0]) : 32'hFFFF, 32'd1);

    // Reset during CMP drops the transaction; next request still completes.
    add(0, 16'h0001, 16'h0002, LT);
    load();
    step();
    chk("t5_grant_r0", 32'(last_ready), 32'b0001);
    add(3, 16'h0100, 16'h00FF, GT);
    load();
    #1 rst = 1'b1;
    #1;
    chk("t5_rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("t5_rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("t5_rst_resp_id", 32'(bus.resp_id), 32'd0);
    chk("t5_rst_flags", 32'({bus.resp_gt, bus.resp_eq, bus.resp_lt}), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    sb.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    step();
    chk("t5_first_grant", 32'(last_ready), 32'b1000);
    drain(1'b0);

    // Mixed vectors on every requester with an irregular consumer.
    add(0, 16'h8000, 16'h7FFF, GT);
    add(0, 16'h0000, 16'h0000, EQ);
    add(1, 16'hFFFF, 16'hFFFF, EQ);
    add(1, 16'h0000, 16'hFFFF, LT);
    add(2, 16'h1235, 16'h1234, GT);
    add(2, 16'hABCD, 16'hABCE, LT);
    add(3, 16'h00FF, 16'h0100, LT);
    add(3, 16'hFFFE, 16'h0001, GT);
    load();
    drain(1'b1);

    repeat (3) step();
    chk("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cmp_share_sched.md
# cmp_share_sched

Round-robin scheduler that shares one unsigned three-way magnitude comparator (greater / equal / less) among `N_REQ` requesters. It sits between the requester-side valid/ready request channels and a single shared response channel. It arbitrates, registers operands, drives the comparator, registers its result and returns that result tagged with the requester ID. Exactly one comparison is in flight at a time.

## Interface
- `N_REQ`, default 4: number of requesters, 2..16.
- `WIDTH`, default 16: operand width in bits.
- `ID_W`, default `$clog2(N_REQ)`: width of the requester ID (derived).

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  N_REQ  per-requester request valid.
- `req_ready`  out  N_REQ  per-requester accept; one-hot or zero.
- `req_a`  in  N_REQ*WIDTH  operand A; requester i uses slice [i*WIDTH +: WIDTH].
- `req_b`  in  N_REQ*WIDTH  operand B; same slicing as `req_a`.
- `resp_valid`  out  1  result available.
- `resp_ready`  in  1  consumer accepts the result.
- `resp_id`  out  ID_W  index of the requester that owns the result.
- `resp_gt`, `resp_eq`, `resp_lt`  out  1 each  A>B, A==B, A<B (unsigned).
- `busy`  out  1  high whenever state is not IDLE.

## Operation
- FSM states: IDLE, CMP, RESP.
- IDLE:
  - If any `req_valid` is high, grant the first valid requester at or after `rr_ptr`, searching upward with wrap-around.
  - `req_ready[grant]` = 1 combinationally in that cycle. That cycle is the handshake.
  - Capture `req_a`/`req_b` of the granted requester and the grant ID into the operand registers.
  - Set `rr_ptr <= (grant+1) mod N_REQ`, then go to CMP.
  - With no valid requests, stay in IDLE.
- CMP: register the comparator outputs and ID into the result registers, then go to RESP. `req_ready` = 0.
- RESP:
  - `resp_valid` = 1; result outputs stay stable.
  - When `resp_ready` = 1, go to IDLE. `resp_valid` drops in the next cycle.
  - While `resp_ready` = 0, hold indefinitely with all outputs stable.
- `req_ready` is 0 in CMP and RESP. Requesters must hold `req_valid` and operands stable until they see `req_ready`.
- Exactly one of `resp_gt`/`resp_eq`/`resp_lt` is 1 whenever `resp_valid` = 1.
- The comparison is unsigned over the full `WIDTH`; there is no sign handling.
- A deasserted `req_valid` is never granted, whatever the pointer position.

## Timing
- Reset values:
  - State IDLE, `rr_ptr` = 0.
  - `req_ready` = 0 (reset forces it 0 even with valid requests present).
  - `resp_valid` = 0, `resp_id` = 0, `resp_gt`/`resp_eq`/`resp_lt` = 0, `busy` = 0.
- Latency: handshake in cycle t → `resp_valid` = 1 from cycle t+2.
- Peak throughput: one result per 3 cycles (IDLE, CMP, RESP with `resp_ready` tied high).
- Back-to-back: the IDLE cycle after the RESP handshake can accept the next request.
- Simultaneous requests: round-robin guarantees that each valid requester is granted within N_REQ grants.
- Reset asserted mid-operation:
  - Immediately (asynchronously) return to IDLE and clear all outputs.
  - An in-flight transaction is dropped with no response.
- Deassertion of `rst` is synchronised externally. The first grant can occur on the first edge after release.

## Structure
- Package `cmp_sched_pkg` holds:
  - the state enum `cmp_state_t` {IDLE, CMP, RESP};
  - the result struct `cmp_res_t` {gt, eq, lt};
  - a `CMP_RES_NONE` constant (all zero).
- Sub-module `cmp3_core`: purely combinational `WIDTH`-bit unsigned three-way comparator returning `cmp_res_t`. It is instantiated once, and is the shared resource.
- Top-level `cmp_share_sched` contains the FSM, round-robin pointer/arbiter, operand registers and result registers.

## Test plan
- Reset, then `req_valid`=0001, A=0x1234, B=0x1234:
  - `req_ready`=0001 in cycle 1.
  - `resp_valid` in cycle 3 with `resp_eq`=1 and `resp_id`=0.
- All four requesters valid with `resp_ready`=1 held:
  - Grant order is 0,1,2,3,0.
  - Requester 2 (A=0xFFFF, B=0x0000) returns `resp_gt`=1.
  - Requester 3 (A=0x0001, B=0x8000) returns `resp_lt`=1.
- `resp_ready`=0 for 10 cycles while in RESP:
  - Outputs stay stable and `req_ready` stays 0.
  - A new request is accepted one cycle after `resp_ready` rises.
- Pointer at 3, only requester 1 valid → requester 1 is granted (wrap-around search).
- `rst` pulsed during CMP:
  - All outputs go to 0 immediately.
  - No response is produced for the dropped request; the next request completes normally.
- Randomised A/B on all requesters, compared against a reference model:
  - Exactly one result flag is set per response.
  - The ID matches the granted requester.
  - No requester waits more than 4 grants.
